fifo_mac_consumer: RTL and testbench
====================================

FIFO_MAC_CONSUMER -- requirements
Module: fifo_mac_consumer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width of each FIFO word.
REQ-002 SHALL have parameter LENGTH, default 8, number of operand pairs per dot product.
REQ-003 SHALL have parameter RESULT_WIDTH, default 24, accumulator/result width; must be >= 2*DATA_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all logic is posedge-triggered.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a dot product.
REQ-007 SHALL have port a_data  input  DATA_WIDTH  registered read data from operand FIFO A.
REQ-008 SHALL have port a_empty  input  1  FIFO A empty flag.
REQ-009 SHALL have port a_rden  output  1  read enable to FIFO A.
REQ-010 SHALL have port b_data  input  DATA_WIDTH  registered read data from operand FIFO B.
REQ-011 SHALL have port b_empty  input  1  FIFO B empty flag.
REQ-012 SHALL have port b_rden  output  1  read enable to FIFO B.
REQ-013 SHALL have port result  output  RESULT_WIDTH  accumulated sum of unsigned a*b products.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 -> RUN next cycle; accumulator and pop counter cleared to 0 on that edge.
REQ-018 RUN: pop = !a_empty && !b_empty && pop_cnt < LENGTH; a_rden = b_rden = pop (combinational, always equal).
REQ-019 Each pop increments pop_cnt; the pop that makes pop_cnt == LENGTH transitions RUN -> DRAIN.
REQ-020 FIFO data is valid the cycle after a pop; a registered pop_d1 SHALL qualify accumulation: acc += a_data*b_data when pop_d1=1.
REQ-021 Product is 2*DATA_WIDTH bits unsigned, zero-extended to RESULT_WIDTH before addition.
REQ-022 DRAIN: accumulates the final pair, -> DONE next cycle; a_rden/b_rden are 0 outside RUN.
REQ-023 DONE: done=1 for exactly one cycle, -> IDLE; result equals final accumulator.
REQ-024 result SHALL hold its value after DONE until the next accepted start.
REQ-025 Either FIFO empty in RUN: no pop, no counter change, state held (stall of arbitrary length).
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 Latency with no stalls: done high exactly LENGTH+2 cycles after the edge that samples start.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, pop_cnt=0, pop_d1=0, accumulator=0 regardless of state.
REQ-029 Reset values: result=0, busy=0, done=0, a_rden=0, b_rden=0; rst has priority over start.
REQ-030 Reset mid-operation SHALL abandon the dot product with no done pulse; unread FIFO contents are left untouched.

Configuration
REQ-031 Macro MAC_SAT_EN defined: accumulation saturates at 2^RESULT_WIDTH-1 and holds there for the rest of the operation.
REQ-032 Macro MAC_SAT_EN undefined: accumulation wraps modulo 2^RESULT_WIDTH.

Verification
REQ-033 Both FIFOs preloaded, A=1..8, B=all 2, start -> done after 10 cycles, result=72, 8 rden pulses per FIFO.
REQ-034 Same data, b_empty forced high 3 cycles after the 4th pop -> no rden during stall, done after 13 cycles, result=72.
REQ-035 RESULT_WIDTH=16, A=B=255 x8 -> result=65535 with MAC_SAT_EN, 61448 without.
REQ-036 rst pulsed after 4th pop -> busy=0, result=0, no done; new start with fresh data -> correct result.
REQ-037 start re-asserted while busy -> ignored, exactly 8 pops, single done pulse, result unchanged from expected.
REQ-038 A preloaded, B empty, start -> busy=1, zero rden pulses, no done until B filled; then normal completion.

Source files
------------

// File: rtl/fifo_mac_consumer.sv
// Dot-product engine that pops LENGTH operand pairs from two FIFOs and accumulates a*b.
// Define MAC_SAT_EN to saturate the accumulator instead of wrapping.
module fifo_mac_consumer #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned LENGTH       = 8,
   parameter int unsigned RESULT_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic                    a_empty,
   output logic                    a_rden,
   input  logic [DATA_WIDTH-1:0]   b_data,
   input  logic                    b_empty,
   output logic                    b_rden,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned CNT_W  = $clog2(LENGTH + 1);
   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned SUM_W  = RESULT_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        pop_cnt_q, pop_cnt_d;
   logic                    pop_d1_q, pop_d1_d;
   logic [RESULT_WIDTH-1:0] acc_q, acc_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic                    pop_c;
   logic [PROD_W-1:0]       prod_c;
   logic [SUM_W-1:0]        sum_c;

   // Next-state, pop decision and accumulation
   always_comb begin
      state_d   = state_q;
      pop_cnt_d = pop_cnt_q;
      acc_d     = acc_q;
      pop_c     = 1'b0;
      prod_c    = PROD_W'(a_data) * PROD_W'(b_data);
      sum_c     = SUM_W'(acc_q) + SUM_W'(prod_c);

      // FIFO read data lags the pop by one cycle
      if (pop_d1_q) begin
`ifdef MAC_SAT_EN
         acc_d = sum_c[RESULT_WIDTH] ? {RESULT_WIDTH{1'b1}} : sum_c[RESULT_WIDTH-1:0];
`else
         acc_d = sum_c[RESULT_WIDTH-1:0];
`endif
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               pop_cnt_d = '0;
               acc_d     = '0;
            end
         end
         RUN: begin
            pop_c = !a_empty && !b_empty && (pop_cnt_q < CNT_W'(LENGTH));
            if (pop_c) begin
               pop_cnt_d = pop_cnt_q + CNT_W'(1);
               if (pop_cnt_q == CNT_W'(LENGTH - 1)) state_d = DRAIN;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      pop_d1_d = pop_c;
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pop_cnt_q <= '0;
         pop_d1_q  <= 1'b0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pop_cnt_q <= pop_cnt_d;
         pop_d1_q  <= pop_d1_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign a_rden = pop_c;
   assign b_rden = pop_c;
   assign result = acc_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_fifo_mac_consumer.sv
// Randomized bench for fifo_mac_consumer: FIFO models feed the DUT, a dot-product model predicts results.
module tb_fifo_mac_consumer;

   localparam int unsigned DW = 8;
   localparam int unsigned L  = 8;
   localparam int unsigned RW = 16;
   localparam longint      MAXV = (64'd1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [DW-1:0] a_data, b_data;
   logic          a_empty, b_empty, a_rden, b_rden;
   logic [RW-1:0] result;
   logic          busy, done;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem_a [0:2047];
   logic [DW-1:0] mem_b [0:2047];
   int  a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
   int  a_pulses = 0, b_pulses = 0;
   bit  hold_a = 1'b0, hold_b = 1'b0, flush = 1'b0, mon_en = 1'b0;

   always #5 clk = ~clk;

   fifo_mac_consumer #(.DATA_WIDTH(DW), .LENGTH(L), .RESULT_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_data(a_data), .a_empty(a_empty), .a_rden(a_rden),
      .b_data(b_data), .b_empty(b_empty), .b_rden(b_rden),
      .result(result), .busy(busy), .done(done)
   );

   assign a_empty = (a_wp == a_rp) || hold_a;
   assign b_empty = (b_wp == b_rp) || hold_b;

   // Two FIFOs with registered read data
   always @(posedge clk) begin
      if (flush) begin
         a_rp <= a_wp;
         b_rp <= b_wp;
      end else begin
         if (a_rden) begin
            a_data   <= mem_a[a_rp];
            a_rp     <= a_rp + 1;
            a_pulses <= a_pulses + 1;
         end
         if (b_rden) begin
            b_data   <= mem_b[b_rp];
            b_rp     <= b_rp + 1;
            b_pulses <= b_pulses + 1;
         end
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Read enables must match and never fire into an empty FIFO
   always @(negedge clk) begin
      if (mon_en) begin
         check("rden_equal", longint'(a_rden), longint'(b_rden));
         check("rden_on_empty", longint'(a_rden && (a_empty || b_empty)), 0);
      end
   end

   // Expected dot product of L pairs starting at the given FIFO positions
   function automatic longint model_dot(input int ba, input int bb);
      longint s = 0;
      for (int i = 0; i < int'(L); i++)
         s += longint'(mem_a[ba + i]) * longint'(mem_b[bb + i]);
`ifdef MAC_SAT_EN
      if (s > MAXV) s = MAXV;
`else
      s = s % (MAXV + 1);
`endif
      return s;
   endfunction

   task automatic stage(input int i, input logic [DW-1:0] av, input logic [DW-1:0] bv);
      mem_a[a_wp + i] = av;
      mem_b[b_wp + i] = bv;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
   endtask

   // One dot product; k counts cycles after the edge that samples start
   task automatic run_op(input int stall_pop, input int stall_len, input bit on_b,
                         input int fill_b_at, input int restart_at, output longint got);
      int     base_a, base_b, pa0, pb0, done_k, n_done, left, exp_lat;
      longint exp_res;
      base_a = a_rp;  base_b = b_rp;
      pa0 = a_pulses; pb0 = b_pulses;
      done_k = 0; n_done = 0; left = stall_len; got = -1;
      exp_lat = int'(L) + 2 + stall_len + ((fill_b_at > 1) ? fill_b_at - 1 : 0);
      a_wp += int'(L);
      if (fill_b_at == 0) b_wp += int'(L);
      start = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (k == fill_b_at) begin
            check("no_pop_b_empty", longint'(a_pulses - pa0), 0);
            b_wp += int'(L);
         end
         if (left > 0 && (a_pulses - pa0) == stall_pop) begin
            if (on_b) hold_b = 1'b1; else hold_a = 1'b1;
            left--;
         end else begin
            hold_a = 1'b0;
            hold_b = 1'b0;
         end
         if (k == 1) check("busy_running", longint'(busy), 1);
         if (done) begin
            n_done++;
            if (done_k == 0) begin
               done_k  = k;
               exp_res = model_dot(base_a, base_b);
               check("result_at_done", longint'(result), exp_res);
            end
         end
         if (done_k != 0 && k >= done_k + 3) break;
      end
      hold_a = 1'b0;
      hold_b = 1'b0;
      start  = 1'b0;
      exp_res = model_dot(base_a, base_b);
      check("latency", longint'(done_k), longint'(exp_lat));
      check("done_pulses", longint'(n_done), 1);
      check("pops_a", longint'(a_pulses - pa0), longint'(L));
      check("pops_b", longint'(b_pulses - pb0), longint'(L));
      check("result_hold", longint'(result), exp_res);
      check("busy_idle", longint'(busy), 0);
      got = longint'(result);
   endtask

   initial begin
      longint got;
      int     p0, n_done;
      rst = 1'b1; start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_result", longint'(result), 0);
      check("rst_rden", longint'(a_rden | b_rden), 0);
      rst = 1'b0; start = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // A=1..8, B=2
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i + 1), DW'(2));
      run_op(0, 0, 1'b0, 0, 0, got);
      check("dot_72", got, 72);

      // Same data, B stalled for 3 cycles after the 4th pop
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i + 1), DW'(2));
      run_op(4, 3, 1'b1, 0, 0, got);
      check("stall_72", got, 72);

      // Overflow: 8 x 255*255 into 16 bits
      for (int i = 0; i < int'(L); i++) stage(i, DW'(255), DW'(255));
      run_op(0, 0, 1'b0, 0, 0, got);
`ifdef MAC_SAT_EN
      check("overflow", got, 65535);
`else
      check("overflow", got, 61448);
`endif

      // Reset after the 4th pop abandons the operation
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i + 3), DW'(i + 5));
      a_wp += int'(L); b_wp += int'(L);
      p0 = a_pulses;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 50 && (a_pulses - p0) < 4; k++) @(negedge clk);
      check("pops_before_rst", longint'(a_pulses - p0), 4);
      hold_a = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", longint'(busy), 0);
      check("midrst_result", longint'(result), 0);
      check("midrst_left", longint'(a_wp - a_rp), longint'(L - 4));
      n_done = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst_no_done", longint'(n_done), 0);
      hold_a = 1'b0;
      do_flush();
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i * 7 + 1), DW'(i + 9));
      run_op(0, 0, 1'b0, 0, 0, got);

      // start re-asserted while busy
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i + 1), DW'(2));
      run_op(0, 0, 1'b0, 0, 3, got);
      check("restart_72", got, 72);

      // B empty at start, filled 5 cycles later
      for (int i = 0; i < int'(L); i++) stage(i, DW'(i + 10), DW'(3));
      run_op(0, 0, 1'b0, 6, 0, got);

      // Random data, stalls and spurious starts
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < int'(L); i++)
            stage(i, DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
         run_op(int'($urandom_range(0, L - 1)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 0,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, L)) : 0, got);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
